dvi_ddr_formatter: RTL and testbench

DVI_DDR_FORMATTER -- requirements
Module: dvi_ddr_formatter

---
 rtl/dvi_ddr_formatter_pkg.sv | 65 ++++++
 rtl/dvi_bar_gen.sv | 48 ++++
 rtl/dvi_ddr_formatter.sv | 138 +++++++++++++
 tb/tb_dvi_ddr_formatter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_ddr_formatter_pkg.sv
// Shared definitions for the DVI DDR formatter.
//   mode_e     : requested/applied output mode encodings
//   BAR_TABLE  : colour-bar test pattern, {r,g,b} per bar index
//   PHASE_W    : width of each DDR phase word
//   pipe_t     : one pipeline slot (phase words, controls, config tag)
package dvi_ddr_formatter_pkg;

   localparam int PHASE_W = 12;
   localparam int PX_W    = 12;
   localparam logic [PX_W-1:0] PX_MAX = '1;

   typedef enum logic [1:0] {
      MODE_RGB888 = 2'd0,
      MODE_RGB565 = 2'd1,
      MODE_BARS   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   typedef enum logic {
      ST_WAIT_VS = 1'b0,
      ST_RUN     = 1'b1
   } state_e;

   typedef logic [23:0] rgb_t;

   // white, yellow, cyan, green, magenta, red, blue, black
   localparam rgb_t BAR_TABLE [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   typedef struct packed {
      logic [PHASE_W-1:0] rise;
      logic [PHASE_W-1:0] fall;
   } phase_t;

   typedef struct packed {
      phase_t ph;
      logic   de;
      logic   hs;
      logic   vs;
      logic   locked;
      mode_e  mode;
   } pipe_t;

   function automatic phase_t pack_rgb888(input rgb_t c);
      phase_t p;
      p.rise = {c[23:16], c[15:12]};
      p.fall = {c[11:8], c[7:0]};
      return p;
   endfunction

   function automatic phase_t pack_rgb565(input rgb_t c);
      phase_t p;
      p.rise = {4'b0, c[23:19], c[15:13]};
      p.fall = {4'b0, c[12:10], c[7:3]};
      return p;
   endfunction

   // Reserved encoding behaves exactly like RGB888.
   function automatic mode_e sanitize_mode(input logic [1:0] m);
      return (m == MODE_RSVD) ? MODE_RGB888 : mode_e'(m);
   endfunction

endpackage

// File: rtl/dvi_bar_gen.sv
// Colour-bar generator: counts DE-high pixels within a line and returns the
// bar colour for the pixel currently presented on de.
//   clk, rst_n : pixel clock, async active-low reset
//   de         : input data enable
//   bar_rgb    : {r,g,b} of the bar for the current pixel
module dvi_bar_gen
   import dvi_ddr_formatter_pkg::*;
#(
   parameter int BAR_W = 80
) (
   input  logic clk,
   input  logic rst_n,
   input  logic de,
   output rgb_t bar_rgb
);

   localparam logic [PX_W-1:0] BAR_LAST = PX_W'(BAR_W - 1);

   logic [PX_W-1:0] px_q;
   logic [PX_W-1:0] bar_left_q;
   logic [2:0]      bar_idx_q;

   // bar_left_q is a down-counter through the current bar; bar_idx_q wraps
   // modulo 8 on its own. Both freeze with px so a saturated line keeps
   // showing the bar belonging to px = 4095.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q       <= '0;
         bar_left_q <= BAR_LAST;
         bar_idx_q  <= '0;
      end else if (!de) begin
         px_q       <= '0;
         bar_left_q <= BAR_LAST;
         bar_idx_q  <= '0;
      end else if (px_q != PX_MAX) begin
         px_q <= px_q + 1'b1;
         if (bar_left_q == '0) begin
            bar_left_q <= BAR_LAST;
            bar_idx_q  <= bar_idx_q + 1'b1;
         end else begin
            bar_left_q <= bar_left_q - 1'b1;
         end
      end
   end

   assign bar_rgb = BAR_TABLE[bar_idx_q];

endmodule

// File: rtl/dvi_ddr_formatter.sv
// DVI DDR formatter: packs RGB pixels (or a colour-bar pattern) into two
// 12-bit phase words per pixel for the external DDR output cells, applies
// sync polarity, and delays everything by PIPE_STAGES cycles.
// Configuration (mode, polarities) is only taken on a VS rising edge.
//   clk, rst_n         : pixel clock, async active-low reset
//   de, hs, vs, r,g,b  : input video
//   mode, hs_pol/vs_pol: requested configuration
//   d_rise, d_fall     : phase words
//   de_o, hs_o, vs_o   : aligned controls
//   locked, cur_mode   : configuration status, aligned with the data
//
// state      | meaning
// ST_WAIT_VS | no configuration applied yet; mode 0, polarity 0, locked = 0
// ST_RUN     | configuration applied at a VS edge; locked = 1
module dvi_ddr_formatter
   import dvi_ddr_formatter_pkg::*;
#(
   parameter int PIPE_STAGES = 2,
   parameter int BAR_W       = 80
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               de,
   input  logic               hs,
   input  logic               vs,
   input  logic [7:0]         r,
   input  logic [7:0]         g,
   input  logic [7:0]         b,
   input  logic [1:0]         mode,
   input  logic               hs_pol,
   input  logic               vs_pol,
   output logic [PHASE_W-1:0] d_rise,
   output logic [PHASE_W-1:0] d_fall,
   output logic               de_o,
   output logic               hs_o,
   output logic               vs_o,
   output logic               locked,
   output logic [1:0]         cur_mode
);

   state_e state_q, state_d;
   logic   vs_q;
   logic   vs_rise;
   mode_e  cfg_mode_q;
   logic   cfg_hs_pol_q, cfg_vs_pol_q;
   mode_e  eff_mode;
   logic   eff_hs_pol, eff_vs_pol, eff_locked;
   rgb_t   bar_rgb;
   pipe_t  stage_in;
   pipe_t  pipe_q [PIPE_STAGES];

   assign vs_rise = vs & ~vs_q;

   dvi_bar_gen #(.BAR_W(BAR_W)) u_bar_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .de      (de),
      .bar_rgb (bar_rgb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_WAIT_VS;
      else        state_q <= state_d;
   end

   // The effective configuration bypasses the applied registers on the
   // VS-edge cycle so the pixel entering with the edge already uses it.
   always_comb begin
      state_d    = state_q;
      eff_mode   = cfg_mode_q;
      eff_hs_pol = cfg_hs_pol_q;
      eff_vs_pol = cfg_vs_pol_q;
      eff_locked = (state_q == ST_RUN);
      case (state_q)
         ST_WAIT_VS: if (vs_rise) state_d = ST_RUN;
         ST_RUN:     state_d = ST_RUN;
         default:    state_d = ST_WAIT_VS;
      endcase
      if (vs_rise) begin
         eff_mode   = sanitize_mode(mode);
         eff_hs_pol = hs_pol;
         eff_vs_pol = vs_pol;
         eff_locked = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q         <= 1'b0;
         cfg_mode_q   <= MODE_RGB888;
         cfg_hs_pol_q <= 1'b0;
         cfg_vs_pol_q <= 1'b0;
      end else begin
         vs_q <= vs;
         if (vs_rise) begin
            cfg_mode_q   <= eff_mode;
            cfg_hs_pol_q <= eff_hs_pol;
            cfg_vs_pol_q <= eff_vs_pol;
         end
      end
   end

   always_comb begin
      stage_in        = '0;
      stage_in.de     = de;
      stage_in.hs     = hs ^ eff_hs_pol;
      stage_in.vs     = vs ^ eff_vs_pol;
      stage_in.locked = eff_locked;
      stage_in.mode   = eff_mode;
      if (de) begin
         case (eff_mode)
            MODE_RGB565: stage_in.ph = pack_rgb565({r, g, b});
            MODE_BARS:   stage_in.ph = pack_rgb888(bar_rgb);
            default:     stage_in.ph = pack_rgb888({r, g, b});
         endcase
      end
   end

   // Data, controls and the configuration tag share one delay line, so
   // they cannot skew relative to each other.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= stage_in;
         for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign d_rise   = pipe_q[PIPE_STAGES-1].ph.rise;
   assign d_fall   = pipe_q[PIPE_STAGES-1].ph.fall;
   assign de_o     = pipe_q[PIPE_STAGES-1].de;
   assign hs_o     = pipe_q[PIPE_STAGES-1].hs;
   assign vs_o     = pipe_q[PIPE_STAGES-1].vs;
   assign locked   = pipe_q[PIPE_STAGES-1].locked;
   assign cur_mode = pipe_q[PIPE_STAGES-1].mode;

endmodule

// File: tb/tb_dvi_ddr_formatter.sv
module tb_dvi_ddr_formatter;

   localparam int BAR_W = 4;
   localparam int N_DUT = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       de, hs, vs;
   logic [7:0] r, g, b;
   logic [1:0] mode;
   logic       hs_pol, vs_pol;

   logic [11:0] d_rise_w   [N_DUT];
   logic [11:0] d_fall_w   [N_DUT];
   logic        de_o_w     [N_DUT];
   logic        hs_o_w     [N_DUT];
   logic        vs_o_w     [N_DUT];
   logic        locked_w   [N_DUT];
   logic [1:0]  cur_mode_w [N_DUT];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
      dvi_ddr_formatter #(.PIPE_STAGES(gi + 1), .BAR_W(BAR_W)) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .de       (de),
         .hs       (hs),
         .vs       (vs),
         .r        (r),
         .g        (g),
         .b        (b),
         .mode     (mode),
         .hs_pol   (hs_pol),
         .vs_pol   (vs_pol),
         .d_rise   (d_rise_w[gi]),
         .d_fall   (d_fall_w[gi]),
         .de_o     (de_o_w[gi]),
         .hs_o     (hs_o_w[gi]),
         .vs_o     (vs_o_w[gi]),
         .locked   (locked_w[gi]),
         .cur_mode (cur_mode_w[gi])
      );
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: expected output word per input cycle.
   logic        m_prev_vs;
   int          m_mode;
   logic        m_hp, m_vp, m_locked;
   int          m_px;
   logic [29:0] hist[$];
   int          valid_from;

   task automatic model_reset();
      m_prev_vs = 1'b0;
      m_mode    = 0;
      m_hp      = 1'b0;
      m_vp      = 1'b0;
      m_locked  = 1'b0;
      m_px      = 0;
   endtask

   function automatic logic [2:0] bar_mask(input int k);
      case (k)
         0: return 3'b111;
         1: return 3'b110;
         2: return 3'b011;
         3: return 3'b010;
         4: return 3'b101;
         5: return 3'b100;
         6: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   task automatic model_eval(output logic [29:0] e);
      int rr, gg, bb, rise, fall;
      logic [2:0] m;
      if (vs && !m_prev_vs) begin
         m_mode   = (mode == 2'd3) ? 0 : int'(mode);
         m_hp     = hs_pol;
         m_vp     = vs_pol;
         m_locked = 1'b1;
      end
      rr = int'(r); gg = int'(g); bb = int'(b);
      if (m_mode == 2) begin
         m  = bar_mask((m_px / BAR_W) % 8);
         rr = m[2] ? 255 : 0;
         gg = m[1] ? 255 : 0;
         bb = m[0] ? 255 : 0;
      end
      if (m_mode == 1) begin
         rise = (rr / 8) * 8 + gg / 32;
         fall = ((gg / 4) % 8) * 32 + bb / 8;
      end else begin
         rise = rr * 16 + gg / 16;
         fall = (gg % 16) * 256 + bb;
      end
      if (!de) begin
         rise = 0;
         fall = 0;
      end
      e = {12'(rise), 12'(fall), de, hs ^ m_hp, vs ^ m_vp, m_locked, 2'(m_mode)};
      if (de) m_px = (m_px < 4095) ? m_px + 1 : 4095;
      else    m_px = 0;
      m_prev_vs = vs;
   endtask

   function automatic logic [29:0] act(input int i);
      return {d_rise_w[i], d_fall_w[i], de_o_w[i], hs_o_w[i], vs_o_w[i], locked_w[i], cur_mode_w[i]};
   endfunction

   // Apply current inputs for one edge, then compare every DUT against the
   // model entry that is PIPE_STAGES cycles old.
   task automatic step();
      logic [29:0] e;
      int idx;
      model_eval(e);
      hist.push_back(e);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N_DUT; i++) begin
         idx = hist.size() - (i + 1);
         chk($sformatf("out_P%0d", i + 1), 32'(act(i)), (idx >= valid_from) ? 32'(hist[idx]) : 32'h0);
      end
   endtask

   task automatic set_px(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
      de = 1'b1; r = rv; g = gv; b = bv;
   endtask

   task automatic rand_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         de = ($urandom_range(3) != 0);
         if ($urandom_range(15) == 0) hs = ~hs;
         if ($urandom_range(30) == 0) vs = ~vs;
         if ($urandom_range(7) == 0) mode = 2'($urandom);
         if ($urandom_range(9) == 0) hs_pol = ~hs_pol;
         if ($urandom_range(9) == 0) vs_pol = ~vs_pol;
         r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      de = 0; hs = 0; vs = 0; r = 0; g = 0; b = 0;
      mode = 0; hs_pol = 0; vs_pol = 0;
      valid_from = 0;
      model_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < N_DUT; i++) chk($sformatf("reset_P%0d", i + 1), 32'(act(i)), 32'h0);
      rst_n = 1'b1;

      // Before any VS edge: requested config ignored, mode 0 / polarity 0.
      mode = 2'd1; hs_pol = 1'b1; vs_pol = 1'b1;
      for (int j = 0; j < 6; j++) begin
         set_px(8'($urandom), 8'($urandom), 8'($urandom));
         hs = j[0];
         step();
         chk("wait_unlocked", 32'(locked_w[0]), 32'h0);
      end

      // VS edge with DE high: new config applies to that very pixel.
      mode = 2'd0; hs_pol = 1'b0; vs_pol = 1'b0; vs = 1'b1; hs = 1'b0;
      set_px(8'hA5, 8'h3C, 8'h96);
      step();
      chk("m0_rise", 32'(d_rise_w[0]), 32'hA53);
      chk("m0_fall", 32'(d_fall_w[0]), 32'hC96);
      chk("m0_locked", 32'(locked_w[0]), 32'h1);
      mode = 2'd1;
      step();
      chk("m0_rise_P2", 32'(d_rise_w[1]), 32'hA53);
      chk("mid_mode_ignored", 32'(d_rise_w[0]), 32'hA53);
      vs = 1'b0;
      step();
      vs = 1'b1;
      step();
      chk("m1_rise", 32'(d_rise_w[0]), 32'h0A1);
      chk("m1_fall", 32'(d_fall_w[0]), 32'h0F2);
      chk("m1_cur_mode", 32'(cur_mode_w[0]), 32'h1);

      // Mid-frame mode/polarity change waits for the next VS edge.
      vs = 1'b0; step();
      mode = 2'd0; hs_pol = 1'b0; vs = 1'b1; step();
      vs = 1'b0; hs = 1'b1; mode = 2'd1; hs_pol = 1'b1;
      step();
      chk("mid_hs_unchanged", 32'(hs_o_w[0]), 32'h1);
      chk("mid_mode0", 32'(d_rise_w[0]), 32'hA53);
      step();
      vs = 1'b1;
      step();
      chk("edge_hs_inverted", 32'(hs_o_w[0]), 32'h0);
      chk("edge_m1_rise", 32'(d_rise_w[0]), 32'h0A1);
      chk("edge_cur_mode", 32'(cur_mode_w[0]), 32'h1);

      // Colour bars over two 40-pixel lines.
      vs = 1'b0; de = 1'b0; hs = 1'b0; hs_pol = 1'b0; step();
      mode = 2'd2; vs = 1'b1; step();
      vs = 1'b0;
      for (int line = 0; line < 2; line++) begin
         for (int j = 0; j < 40; j++) begin
            set_px(8'($urandom), 8'($urandom), 8'($urandom));
            step();
            if (j == 0 || j == 32) begin
               chk("bar_white_rise", 32'(d_rise_w[0]), 32'hFFF);
               chk("bar_white_fall", 32'(d_fall_w[0]), 32'hFFF);
            end
            if (j == 4) begin
               chk("bar_yellow_rise", 32'(d_rise_w[0]), 32'hFFF);
               chk("bar_yellow_fall", 32'(d_fall_w[0]), 32'hF00);
            end
            if (j == 28) chk("bar_black", 32'({d_rise_w[0], d_fall_w[0]}), 32'h0);
         end
         de = 1'b0;
         repeat (3) step();
      end

      // Long line: px saturates, bar stays black instead of wrapping.
      for (int j = 0; j < 4100; j++) begin
         set_px(8'($urandom), 8'($urandom), 8'($urandom));
         step();
      end
      chk("bar_saturated", 32'({d_rise_w[0], d_fall_w[0]}), 32'h0);
      de = 1'b0; step();

      rand_cycles(3000);

      // Reset mid-line: outputs clear at once, relock only at a VS edge.
      set_px(8'hFF, 8'h00, 8'hFF); hs = 1'b1;
      step();
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < N_DUT; i++) chk($sformatf("midrst_P%0d", i + 1), 32'(act(i)), 32'h0);
      vs = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      valid_from = hist.size();
      mode = 2'd2; hs_pol = 1'b1;
      for (int j = 0; j < 6; j++) begin
         set_px(8'($urandom), 8'($urandom), 8'($urandom));
         step();
         chk("post_rst_unlocked", 32'(locked_w[3]), 32'h0);
      end
      vs = 1'b1; step();
      chk("post_rst_relock", 32'(locked_w[0]), 32'h1);

      rand_cycles(2000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
